clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl.sv | 126 ++++++++++++
 tb/tb_clk_gate_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: keeps the downstream gated clock enabled while the
// client requests it or the gated domain is busy. Wakes the clock for a fixed
// settling time before acknowledging, and drains for a fixed idle time before
// shutting it off. All outputs are registered. TEST_EN is the only input with
// a combinational path to an output, and it reaches CLK_EN only.
module clk_gate_ctrl #(
  parameter int unsigned WAKE_CYCLES = 2,  // settling cycles, 1..15
  parameter int unsigned IDLE_CYCLES = 8   // idle cycles before shutoff, 1..255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic       BUSY,
  input  logic       TEST_EN,
  output logic       CLK_EN,
  output logic       ACK,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_WAKE  = 2'b01,
    S_ON    = 2'b10,
    S_DRAIN = 2'b11
  } state_e;

  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES);
  localparam logic [7:0] IDLE_LOAD = 8'(IDLE_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       clk_en_q, clk_en_d;
  logic       ack_q, ack_d;

  logic       activity;
  logic       cnt_last;
  logic [7:0] cnt_dec;

  // Activity is evaluated on sampled levels only; there is no edge detection.
  assign activity = REQ | BUSY;

  // A count of 0 counts as the last cycle, so a zero load can never stall the FSM.
  assign cnt_last = (cnt_q <= 8'd1);

  // Saturating decrement: the counter never wraps below zero.
  assign cnt_dec  = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;

  // State register and registered outputs; synchronous reset aborts any state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_OFF;
      cnt_q    <= 8'd0;
      clk_en_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      ack_q    <= ack_d;
    end
  end

  // Next-state and counter logic.
  // NOTE: every signal written here is given a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_OFF: begin
        if (activity) begin
          state_d = S_WAKE;
          cnt_d   = WAKE_LOAD;
        end else begin
          cnt_d   = 8'd0;
        end
      end
      S_WAKE: begin
        // Settling runs to completion even if the request is withdrawn.
        if (cnt_last) begin
          state_d = S_ON;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_dec;
        end
      end
      S_ON: begin
        if (!activity) begin
          state_d = S_DRAIN;
          cnt_d   = IDLE_LOAD;
        end else begin
          cnt_d   = 8'd0;
        end
      end
      S_DRAIN: begin
        // Renewed activity returns straight to ON: the clock never stopped.
        if (activity) begin
          state_d = S_ON;
          cnt_d   = 8'd0;
        end else if (cnt_last) begin
          state_d = S_OFF;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_dec;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with STATE.
  always_comb begin
    clk_en_d = (state_d != S_OFF);
    ack_d    = (state_d == S_ON) && REQ;
  end

  assign CLK_EN = clk_en_q | TEST_EN;
  assign ACK    = ack_q;
  assign STATE  = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Testbench for clk_gate_ctrl (WAKE_CYCLES=2, IDLE_CYCLES=8). A directed
// stimulus process drives one row per cycle and pushes the hand-computed
// outputs for that cycle into a scoreboard; a monitor pops and compares on the
// falling edge.
module tb_clk_gate_ctrl;

  localparam logic [1:0] OFF   = 2'b00;
  localparam logic [1:0] WAKE  = 2'b01;
  localparam logic [1:0] ON    = 2'b10;
  localparam logic [1:0] DRAIN = 2'b11;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       ce;
    logic       ack;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ = 1'b0;
  logic       BUSY = 1'b0;
  logic       TEST_EN = 1'b0;
  logic       CLK_EN;
  logic       ACK;
  logic [1:0] STATE;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  clk_gate_ctrl #(.WAKE_CYCLES(2), .IDLE_CYCLES(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .BUSY    (BUSY),
    .TEST_EN (TEST_EN),
    .CLK_EN  (CLK_EN),
    .ACK     (ACK),
    .STATE   (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got state=%b clk_en=%b ack=%b, expected state=%b clk_en=%b ack=%b",
               nm, got[3:2], got[1], got[0], want[3:2], want[1], want[0]);
    end
  endtask

  // One cycle: drive this row's inputs just after the rising edge and record
  // the outputs expected during this cycle (TEST_EN acts within the cycle).
  task automatic step(input logic rs, input logic rq, input logic bz, input logic te,
                      input logic [1:0] st, input logic ce, input logic ak, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rs; REQ = rq; BUSY = bz; TEST_EN = te;
    e.name = nm; e.st = st; e.ce = ce; e.ack = ak;
    sb.push_back(e);
  endtask

  // Monitor: compares whatever is pending for this cycle.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, {STATE, CLK_EN, ACK}, {e.st, e.ce, e.ack});
    end
  end

  initial begin
    // Reset with REQ held through it, then wake (2 cycles), ON with ACK.
    step(1, 1, 0, 0, OFF,  0, 0, "reset");
    step(0, 1, 0, 0, OFF,  0, 0, "reset_last_edge");
    step(0, 1, 0, 0, WAKE, 1, 0, "wake_1");
    step(0, 1, 0, 0, WAKE, 1, 0, "wake_2");
    step(0, 1, 0, 0, ON,   1, 1, "on_ack");
    step(0, 0, 0, 0, ON,   1, 1, "on_hold");
    // Idle from ON: 8 DRAIN cycles with clock enabled, then OFF.
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, DRAIN, 1, 0, "drain_full");
    step(0, 1, 0, 0, OFF,  0, 0, "drain_to_off");

    // Wake again, drain down to count 3, BUSY pulse returns to ON without ACK.
    step(0, 1, 0, 0, WAKE, 1, 0, "rewake_1");
    step(0, 1, 0, 0, WAKE, 1, 0, "rewake_2");
    step(0, 0, 0, 0, ON,   1, 1, "rewake_on");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, DRAIN, 1, 0, "drain_partial");
    step(0, 0, 1, 0, DRAIN, 1, 0, "drain_cnt3");
    step(0, 0, 0, 0, ON,   1, 0, "busy_return_on");
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, DRAIN, 1, 0, "drain_after_busy");
    step(0, 1, 0, 0, OFF,  0, 0, "drain2_to_off");

    // Single-cycle REQ pulse: full WAKE, one ON cycle without ACK, full DRAIN.
    step(0, 0, 0, 0, WAKE, 1, 0, "pulse_wake_1");
    step(0, 0, 0, 0, WAKE, 1, 0, "pulse_wake_2");
    step(0, 0, 0, 0, ON,   1, 0, "pulse_on_noack");
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, DRAIN, 1, 0, "pulse_drain");
    step(0, 1, 0, 0, OFF,  0, 0, "pulse_off");

    // Reset mid-WAKE, then reset mid-DRAIN.
    step(1, 1, 0, 0, WAKE, 1, 0, "pre_rst_wake");
    step(0, 1, 0, 0, OFF,  0, 0, "rst_in_wake");
    step(0, 1, 0, 0, WAKE, 1, 0, "post_rst_wake_1");
    step(0, 1, 0, 0, WAKE, 1, 0, "post_rst_wake_2");
    step(0, 0, 0, 0, ON,   1, 1, "post_rst_on");
    step(0, 0, 0, 0, DRAIN, 1, 0, "pre_rst_drain_1");
    step(1, 0, 0, 0, DRAIN, 1, 0, "pre_rst_drain_2");
    step(0, 0, 0, 0, OFF,  0, 0, "rst_in_drain");

    // REQ during DRAIN returns to ON with ACK.
    step(0, 1, 0, 0, OFF,  0, 0, "idle_off");
    step(0, 1, 0, 0, WAKE, 1, 0, "wake3_1");
    step(0, 1, 0, 0, WAKE, 1, 0, "wake3_2");
    step(0, 0, 0, 0, ON,   1, 1, "on3_ack");
    step(0, 1, 0, 0, DRAIN, 1, 0, "drain3");
    step(0, 1, 0, 0, ON,   1, 1, "drain_req_ack");
    step(0, 0, 0, 0, ON,   1, 1, "on3_hold");

    // TEST_EN: forces CLK_EN during reset and in OFF, same cycle, FSM untouched.
    step(1, 0, 0, 0, DRAIN, 1, 0, "drain4");
    step(1, 0, 0, 1, OFF,  1, 0, "test_en_in_reset");
    step(0, 0, 0, 1, OFF,  1, 0, "test_en_reset_last");
    step(0, 0, 0, 0, OFF,  0, 0, "test_en_released");
    step(0, 0, 0, 1, OFF,  1, 0, "test_en_off");
    step(0, 0, 0, 0, OFF,  0, 0, "test_en_off_released");

    @(negedge CLK);
    #1;
    check("scoreboard_empty", 4'(sb.size()), 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
